mbus_layer_if: RTL

//  Layer-side counterpart of the MBus node's TX/RX handshake. It accepts RX words
//  (4-phase RX_REQ/RX_ACK) and turns register-write messages into local register

---
 rtl/mbus_layer_if_pkg.sv | 44 ++++
 rtl/mbus_layer_if_if.sv | 52 +++++
 rtl/mbus_lif_sync.sv | 16 +
 rtl/mbus_layer_if.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mbus_layer_if_pkg.sv
// mbus_layer_if_pkg: shared widths, function IDs, field positions, FSM states and register bundle (MBUS_LIF_RDRESP_EN adds read-reply state)
package mbus_layer_if_pkg;
   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 32;
   localparam int REG_DW       = 24;
   localparam logic [3:0] FUNC_REG_WR = 4'd0;
   localparam logic [3:0] FUNC_REG_RD = 4'd1;
   localparam int WR_ADDR_LSB  = 24;
   localparam int WR_DATA_LSB  = 0;
   localparam int RD_START_LSB = 24;
   localparam int RD_CNT_LSB   = 16;
   localparam int RD_REPLY_LSB = 8;
   localparam int RD_DEST_LSB  = 0;

   typedef enum logic [2:0] {
      IDLE, RX_HOLD, TX_DRIVE, TX_RELEASE, TX_WAIT, TX_RESP
`ifdef MBUS_LIF_RDRESP_EN
      , RD_FETCH
`endif
   } state_t;

   typedef struct packed {
      logic                  rx_ack;
      logic                  reg_wr_en;
      logic [7:0]            wr_addr;
      logic [REG_DW-1:0]     wr_data;
      logic [ADDR_WIDTH-1:0] tx_addr;
      logic [DATA_WIDTH-1:0] tx_data;
      logic                  tx_pend;
      logic                  tx_req;
      logic                  tx_resp_ack;
      logic                  loc_ack;
      logic                  loc_done;
      logic                  loc_err;
      logic                  lock;
`ifdef MBUS_LIF_RDRESP_EN
      logic                  rd_act;
      logic [7:0]            rd_addr;
      logic [7:0]            rd_cnt;
      logic [7:0]            rd_reply;
      logic [7:0]            rd_dest;
`endif
   } regs_t;
endpackage

// File: rtl/mbus_layer_if_if.sv
// mbus_layer_if_if: node, register-file and local-agent signals of the layer interface (MBUS_LIF_RDRESP_EN adds read port)
interface mbus_layer_if_if #(parameter int REG_AW = 8);
   import mbus_layer_if_pkg::*;
   logic [ADDR_WIDTH-1:0] RX_ADDR;
   logic [DATA_WIDTH-1:0] RX_DATA;
   logic                  RX_PEND;
   logic                  RX_REQ;
   logic                  RX_ACK;
   logic                  RX_FAIL;
   logic [ADDR_WIDTH-1:0] TX_ADDR;
   logic [DATA_WIDTH-1:0] TX_DATA;
   logic                  TX_PEND;
   logic                  TX_REQ;
   logic                  TX_ACK;
   logic                  TX_SUCC;
   logic                  TX_FAIL;
   logic                  TX_RESP_ACK;
   logic                  REG_WR_EN;
   logic [REG_AW-1:0]     REG_WR_ADDR;
   logic [REG_DW-1:0]     REG_WR_DATA;
   logic                  LOC_TX_REQ;
   logic [ADDR_WIDTH-1:0] LOC_TX_ADDR;
   logic [DATA_WIDTH-1:0] LOC_TX_DATA;
   logic                  LOC_TX_PEND;
   logic                  LOC_TX_ACK;
   logic                  LOC_TX_DONE;
   logic                  LOC_TX_ERR;
`ifdef MBUS_LIF_RDRESP_EN
   logic [REG_AW-1:0]     REG_RD_ADDR;
   logic [REG_DW-1:0]     REG_RD_DATA;
`endif

   modport slave (
      input  RX_ADDR, RX_DATA, RX_PEND, RX_REQ, RX_FAIL, TX_ACK, TX_SUCC, TX_FAIL,
             LOC_TX_REQ, LOC_TX_ADDR, LOC_TX_DATA, LOC_TX_PEND,
      output RX_ACK, TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_RESP_ACK,
             REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, LOC_TX_ACK, LOC_TX_DONE, LOC_TX_ERR
`ifdef MBUS_LIF_RDRESP_EN
      , output REG_RD_ADDR, input REG_RD_DATA
`endif
   );

   modport master (
      output RX_ADDR, RX_DATA, RX_PEND, RX_REQ, RX_FAIL, TX_ACK, TX_SUCC, TX_FAIL,
             LOC_TX_REQ, LOC_TX_ADDR, LOC_TX_DATA, LOC_TX_PEND,
      input  RX_ACK, TX_ADDR, TX_DATA, TX_PEND, TX_REQ, TX_RESP_ACK,
             REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, LOC_TX_ACK, LOC_TX_DONE, LOC_TX_ERR
`ifdef MBUS_LIF_RDRESP_EN
      , input REG_RD_ADDR, output REG_RD_DATA
`endif
   );
endinterface

// File: rtl/mbus_lif_sync.sv
// mbus_lif_sync: SYNC_STAGES-deep single-bit synchronizer with synchronous active-low clear
module mbus_lif_sync #(parameter int SYNC_STAGES = 2) (
   input  logic CLKIN,
   input  logic RESETn,
   input  logic d_i,
   output logic q_o
);
   logic [SYNC_STAGES-1:0] sync_q;

   // shift the input through the flop chain, oldest sample at the top
   always_ff @(posedge CLKIN)
      if (!RESETn) sync_q <= '0;
      else sync_q <= SYNC_STAGES'({sync_q, d_i});

   assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/mbus_layer_if.sv
// mbus_layer_if: layer-side RX/TX 4-phase handshake engine with register writes (MBUS_LIF_RDRESP_EN enables register-read replies)
module mbus_layer_if
   import mbus_layer_if_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int REG_AW      = 8
) (
   input logic           CLKIN,
   input logic           RESETn,
   mbus_layer_if_if.slave bus
);
   state_t     state_q, state_d;
   regs_t      r_q, r_d;
   logic [6:0] hs_raw, hs_s;
   logic       loc_req_s, tx_ack_s, rx_req_s, rx_pend_s, rx_fail_s, tx_succ_s, tx_fail_s;
   logic [3:0] fid;

   // local request goes through an equal-length delay so a simultaneous RX_REQ wins arbitration
   assign hs_raw = {bus.LOC_TX_REQ, bus.TX_ACK, bus.RX_REQ, bus.RX_PEND, bus.RX_FAIL, bus.TX_SUCC, bus.TX_FAIL};
   for (genvar i = 0; i < 7; i++) begin : g_sync
      mbus_lif_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .CLKIN (CLKIN),
         .RESETn(RESETn),
         .d_i   (hs_raw[i]),
         .q_o   (hs_s[i])
      );
   end
   assign {loc_req_s, tx_ack_s, rx_req_s, rx_pend_s, rx_fail_s, tx_succ_s, tx_fail_s} = hs_s;
   assign fid = bus.RX_ADDR[3:0];

   // state and registered outputs; everything clears on reset
   always_ff @(posedge CLKIN)
      if (!RESETn) begin
         state_q <= IDLE;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
      end

   // next state and next output values; strobes default low every cycle
   always_comb begin
      state_d       = state_q;
      r_d           = r_q;
      r_d.reg_wr_en = 1'b0;
      r_d.loc_ack   = 1'b0;
      r_d.loc_done  = 1'b0;
      r_d.loc_err   = 1'b0;
      case (state_q)
         IDLE:
            if (rx_req_s && !r_q.lock) begin
               state_d       = RX_HOLD;
               r_d.rx_ack    = 1'b1;
               r_d.reg_wr_en = fid == FUNC_REG_WR && !rx_fail_s;
               r_d.wr_addr   = bus.RX_DATA[WR_ADDR_LSB +: 8];
               r_d.wr_data   = bus.RX_DATA[WR_DATA_LSB +: REG_DW];
`ifdef MBUS_LIF_RDRESP_EN
               r_d.rd_act    = fid == FUNC_REG_RD && !rx_fail_s;
               r_d.rd_addr   = bus.RX_DATA[RD_START_LSB +: 8];
               r_d.rd_cnt    = bus.RX_DATA[RD_CNT_LSB +: 8];
               r_d.rd_reply  = bus.RX_DATA[RD_REPLY_LSB +: 8];
               r_d.rd_dest   = bus.RX_DATA[RD_DEST_LSB +: 8];
`endif
            end else if (loc_req_s) begin
               state_d     = TX_DRIVE;
               r_d.loc_ack = 1'b1;
               r_d.tx_data = bus.LOC_TX_DATA;
               r_d.tx_pend = bus.LOC_TX_PEND;
               r_d.tx_req  = 1'b1;
               r_d.tx_addr = r_q.lock ? r_q.tx_addr : bus.LOC_TX_ADDR;
            end
         RX_HOLD:
            if (!rx_req_s) begin
               r_d.rx_ack = 1'b0;
               state_d    = IDLE;
`ifdef MBUS_LIF_RDRESP_EN
               if (r_q.rd_act) state_d = RD_FETCH;
`endif
            end
         TX_DRIVE:
            if (tx_ack_s) begin
               r_d.tx_req = 1'b0;
               state_d    = TX_RELEASE;
            end
         TX_RELEASE:
            if (!tx_ack_s) begin
               state_d  = r_q.tx_pend ? IDLE : TX_WAIT;
               r_d.lock = r_q.tx_pend;
`ifdef MBUS_LIF_RDRESP_EN
               if (r_q.rd_act && r_q.tx_pend) begin
                  state_d     = RD_FETCH;
                  r_d.lock    = 1'b0;
                  r_d.rd_addr = r_q.rd_addr + 8'd1;
                  r_d.rd_cnt  = r_q.rd_cnt - 8'd1;
                  r_d.rd_dest = r_q.rd_dest + 8'd1;
               end
`endif
            end
         TX_WAIT:
            if (tx_succ_s || tx_fail_s) begin
               state_d         = TX_RESP;
               r_d.tx_resp_ack = 1'b1;
               r_d.loc_err     = tx_fail_s;
               r_d.loc_done    = !tx_fail_s;
`ifdef MBUS_LIF_RDRESP_EN
               if (r_q.rd_act) begin
                  r_d.loc_err  = 1'b0;
                  r_d.loc_done = 1'b0;
               end
`endif
            end
         TX_RESP:
            if (!tx_succ_s && !tx_fail_s) begin
               state_d         = IDLE;
               r_d.tx_resp_ack = 1'b0;
`ifdef MBUS_LIF_RDRESP_EN
               r_d.rd_act      = 1'b0;
`endif
            end
`ifdef MBUS_LIF_RDRESP_EN
         RD_FETCH: begin
            state_d     = TX_DRIVE;
            r_d.tx_addr = {24'h0, r_q.rd_reply};
            r_d.tx_data = {r_q.rd_dest, bus.REG_RD_DATA};
            r_d.tx_pend = r_q.rd_cnt != 8'd0;
            r_d.tx_req  = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign bus.RX_ACK      = r_q.rx_ack;
   assign bus.TX_ADDR     = r_q.tx_addr;
   assign bus.TX_DATA     = r_q.tx_data;
   assign bus.TX_PEND     = r_q.tx_pend;
   assign bus.TX_REQ      = r_q.tx_req;
   assign bus.TX_RESP_ACK = r_q.tx_resp_ack;
   assign bus.REG_WR_EN   = r_q.reg_wr_en;
   assign bus.REG_WR_ADDR = REG_AW'(r_q.wr_addr);
   assign bus.REG_WR_DATA = r_q.wr_data;
   assign bus.LOC_TX_ACK  = r_q.loc_ack;
   assign bus.LOC_TX_DONE = r_q.loc_done;
   assign bus.LOC_TX_ERR  = r_q.loc_err;
`ifdef MBUS_LIF_RDRESP_EN
   assign bus.REG_RD_ADDR = REG_AW'(r_q.rd_addr);
`endif
endmodule
